// File: rtl/vtpg_cfg_ctrl.sv
// Configuration and sequencing controller for the video timing pattern generator.
// Shadow timing registers behind a register bus; commits land on active timing at frame boundaries.
module vtpg_cfg_ctrl #(
    parameter int H_BITS    = 12,
    parameter int V_BITS    = 12,
    parameter int FCNT_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              rd_en,
    input  logic [3:0]        rd_addr,
    output logic [15:0]       rd_data,
    output logic              rd_vld,
    input  logic              vs,
    output logic              vtpg_rst_n,
    output logic [H_BITS-1:0] tH_END,
    output logic [H_BITS-1:0] tHS_START,
    output logic [H_BITS-1:0] tHS_END,
    output logic [H_BITS-1:0] tHACT_START,
    output logic [H_BITS-1:0] tHACT_END,
    output logic [V_BITS-1:0] tVS_START,
    output logic [V_BITS-1:0] tVS_END,
    output logic [V_BITS-1:0] tVACT_START,
    output logic [V_BITS-1:0] tVACT_END
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_STOP_WAIT = 2'd3;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'hA;
    localparam logic [3:0] A_FCNT   = 4'hB;

    // Power-on timing is standard 640x480 so the generator is usable without setup.
    function automatic logic [H_BITS-1:0] h_rst(input int idx);
        case (idx)
            0:       return H_BITS'(799);
            1:       return H_BITS'(656);
            2:       return H_BITS'(752);
            3:       return H_BITS'(0);
            default: return H_BITS'(640);
        endcase
    endfunction

    function automatic logic [V_BITS-1:0] v_rst(input int idx);
        case (idx)
            0:       return V_BITS'(490);
            1:       return V_BITS'(492);
            2:       return V_BITS'(0);
            default: return V_BITS'(480);
        endcase
    endfunction

    logic [H_BITS-1:0]    sh_h_q  [5];
    logic [H_BITS-1:0]    sh_h_d  [5];
    logic [H_BITS-1:0]    act_h_q [5];
    logic [H_BITS-1:0]    act_h_d [5];
    logic [V_BITS-1:0]    sh_v_q  [4];
    logic [V_BITS-1:0]    sh_v_d  [4];
    logic [V_BITS-1:0]    act_v_q [4];
    logic [V_BITS-1:0]    act_v_d [4];

    logic [1:0]           state_q, state_d;
    logic                 enable_q, enable_d;
    logic                 pending_q, pending_d;
    logic [FCNT_BITS-1:0] fcnt_q, fcnt_d;
    logic                 vs_q, vs_d;
    logic                 vtpg_rst_n_q, vtpg_rst_n_d;
    logic [15:0]          rd_data_q, rd_data_d;
    logic                 rd_vld_q, rd_vld_d;

    logic                 vs_rise, vs_fall, in_run, apply, ctrl_wr;
    logic [15:0]          rd_word;
    logic                 unused_wr_bits;

    assign unused_wr_bits = ^wr_data;

    assign vs_rise = vs & ~vs_q;
    assign vs_fall = ~vs & vs_q;
    assign in_run  = (state_q == ST_RUN) || (state_q == ST_STOP_WAIT);
    assign ctrl_wr = wr_en && (wr_addr == A_CTRL);
    // Outside of running states a pending commit is applied immediately; while running, only on vs rise.
    assign apply   = pending_q &&
                     ((state_q == ST_IDLE) || (state_q == ST_START) || (in_run && vs_rise));

    always_comb begin
        sh_h_d  = sh_h_q;
        sh_v_d  = sh_v_q;
        act_h_d = act_h_q;
        act_v_d = act_v_q;
        for (int i = 0; i < 5; i++) begin
            if (wr_en && (wr_addr == 4'(i + 1))) sh_h_d[i] = wr_data[H_BITS-1:0];
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_en && (wr_addr == 4'(i + 6))) sh_v_d[i] = wr_data[V_BITS-1:0];
        end
        // Active copies the pre-write shadow, so a same-cycle shadow write waits for the next commit.
        if (apply) begin
            act_h_d = sh_h_q;
            act_v_d = sh_v_q;
        end
    end

    always_comb begin
        enable_d  = ctrl_wr ? wr_data[0] : enable_q;
        pending_d = pending_q;
        if (apply) pending_d = 1'b0;
        if (ctrl_wr && wr_data[1]) pending_d = 1'b1;

        fcnt_d = fcnt_q;
        if (in_run && vs_rise) fcnt_d = fcnt_q + FCNT_BITS'(1);
        if (wr_en && (wr_addr == A_FCNT)) fcnt_d = '0;

        vs_d    = vs;
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (enable_q) state_d = ST_START;
            ST_START:     state_d = ST_RUN;
            ST_RUN:       if (!enable_q) state_d = ST_STOP_WAIT;
            ST_STOP_WAIT: begin
                if (enable_q)     state_d = ST_RUN;
                else if (vs_fall) state_d = ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
        vtpg_rst_n_d = (state_d == ST_RUN) || (state_d == ST_STOP_WAIT);
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 5; i++) begin
            if (rd_addr == 4'(i + 1)) rd_word = 16'(sh_h_q[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (rd_addr == 4'(i + 6)) rd_word = 16'(sh_v_q[i]);
        end
        if (rd_addr == A_CTRL)   rd_word = {15'b0, enable_q};
        if (rd_addr == A_STATUS) rd_word = {12'b0, state_q, pending_q, state_q == ST_RUN};
        if (rd_addr == A_FCNT)   rd_word = 16'(fcnt_q);

        rd_vld_d  = rd_en;
        rd_data_d = rd_en ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                sh_h_q[i]  <= h_rst(i);
                act_h_q[i] <= h_rst(i);
            end
            for (int i = 0; i < 4; i++) begin
                sh_v_q[i]  <= v_rst(i);
                act_v_q[i] <= v_rst(i);
            end
            state_q      <= ST_IDLE;
            enable_q     <= 1'b0;
            pending_q    <= 1'b0;
            fcnt_q       <= '0;
            vs_q         <= 1'b0;
            vtpg_rst_n_q <= 1'b0;
            rd_data_q    <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            sh_h_q       <= sh_h_d;
            act_h_q      <= act_h_d;
            sh_v_q       <= sh_v_d;
            act_v_q      <= act_v_d;
            state_q      <= state_d;
            enable_q     <= enable_d;
            pending_q    <= pending_d;
            fcnt_q       <= fcnt_d;
            vs_q         <= vs_d;
            vtpg_rst_n_q <= vtpg_rst_n_d;
            rd_data_q    <= rd_data_d;
            rd_vld_q     <= rd_vld_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_vld      = rd_vld_q;
    assign vtpg_rst_n  = vtpg_rst_n_q;
    assign tH_END      = act_h_q[0];
    assign tHS_START   = act_h_q[1];
    assign tHS_END     = act_h_q[2];
    assign tHACT_START = act_h_q[3];
    assign tHACT_END   = act_h_q[4];
    assign tVS_START   = act_v_q[0];
    assign tVS_END     = act_v_q[1];
    assign tVACT_START = act_v_q[2];
    assign tVACT_END   = act_v_q[3];

endmodule

// File: tb/tb_vtpg_cfg_ctrl.sv
// Directed bench for vtpg_cfg_ctrl: register bus, start/stop sequencing, frame-boundary commits.
module tb_vtpg_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, vs = 1'b0;
    logic [3:0]  wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        rd_vld, vtpg_rst_n;
    logic [11:0] tH_END, tHS_START, tHS_END, tHACT_START, tHACT_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END;

    int n_cmp = 0;
    int n_bad = 0;

    vtpg_cfg_ctrl #(.H_BITS(12), .V_BITS(12), .FCNT_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
        .vs(vs), .vtpg_rst_n(vtpg_rst_n),
        .tH_END(tH_END), .tHS_START(tHS_START), .tHS_END(tHS_END),
        .tHACT_START(tHACT_START), .tHACT_END(tHACT_END),
        .tVS_START(tVS_START), .tVS_END(tVS_END),
        .tVACT_START(tVACT_START), .tVACT_END(tVACT_END)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        $display("wr  addr=%h data=%0d", a, d);
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d, output logic v);
        @(negedge clk);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data; v = rd_vld;
        $display("rd  addr=%h data=%0d vld=%0b", a, d, v);
    endtask

    task automatic vs_pulse();
        @(negedge clk); vs = 1'b1;
        @(negedge clk); vs = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d; logic v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (vtpg_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_vtpg_rst_n got %0b want 0", vtpg_rst_n); end
        n_cmp++; if (tH_END !== 12'd799) begin n_bad++; $display("FAIL reset_tH_END got %0d want 799", tH_END); end
        n_cmp++; if (tVS_START !== 12'd490) begin n_bad++; $display("FAIL reset_tVS_START got %0d want 490", tVS_START); end
        n_cmp++; if (tVACT_END !== 12'd480) begin n_bad++; $display("FAIL reset_tVACT_END got %0d want 480", tVACT_END); end
        n_cmp++; if (rd_vld !== 1'b0 || rd_data !== 16'd0) begin n_bad++; $display("FAIL reset_rd got %0d/%0b want 0/0", rd_data, rd_vld); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        rd(4'h1, d, v);
        n_cmp++; if (d !== 16'd799 || v !== 1'b1) begin n_bad++; $display("FAIL rd_reg1 got %0d/%0b want 799/1", d, v); end
        @(negedge clk);
        n_cmp++; if (rd_vld !== 1'b0 || rd_data !== 16'd799) begin n_bad++; $display("FAIL rd_hold got %0d/%0b want 799/0", rd_data, rd_vld); end
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd0 || v !== 1'b1) begin n_bad++; $display("FAIL rd_status_idle got %0d/%0b want 0/1", d, v); end
        rd(4'hE, d, v);
        n_cmp++; if (d !== 16'd0 || v !== 1'b1) begin n_bad++; $display("FAIL rd_unmapped got %0d/%0b want 0/1", d, v); end
    endtask

    task automatic test_start();
        logic [15:0] d; logic v;
        wr(4'h5, 16'd320);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'h0; wr_data = 16'h3;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (vtpg_rst_n !== 1'b0) begin n_bad++; $display("FAIL start_cyc1_rst got %0b want 0", vtpg_rst_n); end
        @(negedge clk);
        n_cmp++; if (tHACT_END !== 12'd320) begin n_bad++; $display("FAIL start_tHACT_END got %0d want 320", tHACT_END); end
        n_cmp++; if (vtpg_rst_n !== 1'b0) begin n_bad++; $display("FAIL start_cyc2_rst got %0b want 0", vtpg_rst_n); end
        @(negedge clk);
        n_cmp++; if (vtpg_rst_n !== 1'b1) begin n_bad++; $display("FAIL start_run_rst got %0b want 1", vtpg_rst_n); end
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd9) begin n_bad++; $display("FAIL start_status got %0d want 9", d); end
    endtask

    task automatic test_commit();
        logic [15:0] d; logic v;
        wr(4'h1, 16'd999);
        wr(4'h0, 16'h3);
        repeat (50) @(negedge clk);
        n_cmp++; if (tH_END !== 12'd799) begin n_bad++; $display("FAIL commit_hold got %0d want 799", tH_END); end
        vs = 1'b1;
        @(negedge clk);
        n_cmp++; if (tH_END !== 12'd999) begin n_bad++; $display("FAIL commit_apply got %0d want 999", tH_END); end
        vs = 1'b0;
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd9) begin n_bad++; $display("FAIL commit_status got %0d want 9", d); end
    endtask

    task automatic test_coincident();
        logic [15:0] d; logic v;
        wr(4'h2, 16'd700);
        wr(4'h0, 16'h3);
        @(negedge clk);
        vs = 1'b1; wr_en = 1'b1; wr_addr = 4'h0; wr_data = 16'h3;
        @(negedge clk);
        vs = 1'b0; wr_en = 1'b0;
        n_cmp++; if (tHS_START !== 12'd700) begin n_bad++; $display("FAIL coinc_tHS_START got %0d want 700", tHS_START); end
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd11) begin n_bad++; $display("FAIL coinc_status got %0d want 11", d); end
        @(negedge clk);
        vs = 1'b1; wr_en = 1'b1; wr_addr = 4'h3; wr_data = 16'd760;
        @(negedge clk);
        vs = 1'b0; wr_en = 1'b0;
        n_cmp++; if (tHS_END !== 12'd752) begin n_bad++; $display("FAIL shadow_coinc_active got %0d want 752", tHS_END); end
        rd(4'h3, d, v);
        n_cmp++; if (d !== 16'd760) begin n_bad++; $display("FAIL shadow_coinc_shadow got %0d want 760", d); end
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd9) begin n_bad++; $display("FAIL shadow_coinc_status got %0d want 9", d); end
    endtask

    task automatic test_rw_same();
        logic [15:0] d; logic v;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'h1; wr_data = 16'd555;
        rd_en = 1'b1; rd_addr = 4'h1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        n_cmp++; if (rd_data !== 16'd999 || rd_vld !== 1'b1) begin n_bad++; $display("FAIL rw_same got %0d/%0b want 999/1", rd_data, rd_vld); end
        rd(4'h1, d, v);
        n_cmp++; if (d !== 16'd555) begin n_bad++; $display("FAIL rw_after got %0d want 555", d); end
    endtask

    task automatic test_frame_cnt();
        logic [15:0] d; logic v;
        wr(4'hB, 16'd0);
        repeat (3) vs_pulse();
        rd(4'hB, d, v);
        n_cmp++; if (d !== 16'd3) begin n_bad++; $display("FAIL fcnt_three got %0d want 3", d); end
        @(negedge clk);
        vs = 1'b1; wr_en = 1'b1; wr_addr = 4'hB; wr_data = 16'hFFFF;
        @(negedge clk);
        vs = 1'b0; wr_en = 1'b0;
        rd(4'hB, d, v);
        n_cmp++; if (d !== 16'd0) begin n_bad++; $display("FAIL fcnt_clear_on_rise got %0d want 0", d); end
        repeat (17) vs_pulse();
        rd(4'hB, d, v);
        n_cmp++; if (d !== 16'd1) begin n_bad++; $display("FAIL fcnt_wrap got %0d want 1", d); end
    endtask

    task automatic test_stop();
        logic [15:0] d; logic v;
        @(negedge clk); vs = 1'b1;
        wr(4'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (vtpg_rst_n !== 1'b1) begin n_bad++; $display("FAIL stop_wait_rst[%0d] got %0b want 1", i, vtpg_rst_n); end
        end
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd12) begin n_bad++; $display("FAIL stop_wait_status got %0d want 12", d); end
        @(negedge clk); vs = 1'b0;
        @(negedge clk);
        n_cmp++; if (vtpg_rst_n !== 1'b0) begin n_bad++; $display("FAIL stop_fall_rst got %0b want 0", vtpg_rst_n); end
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd0) begin n_bad++; $display("FAIL stop_idle_status got %0d want 0", d); end
    endtask

    task automatic test_reenable();
        logic [15:0] d; logic v;
        wr(4'h0, 16'h1);
        repeat (2) @(negedge clk);
        n_cmp++; if (vtpg_rst_n !== 1'b1) begin n_bad++; $display("FAIL reen_run_rst got %0b want 1", vtpg_rst_n); end
        @(negedge clk); vs = 1'b1;
        wr(4'h0, 16'h0);
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd12) begin n_bad++; $display("FAIL reen_stop_status got %0d want 12", d); end
        wr(4'h0, 16'h1);
        n_cmp++; if (vtpg_rst_n !== 1'b1) begin n_bad++; $display("FAIL reen_no_pulse got %0b want 1", vtpg_rst_n); end
        @(negedge clk); vs = 1'b0;
        @(negedge clk);
        n_cmp++; if (vtpg_rst_n !== 1'b1) begin n_bad++; $display("FAIL reen_after_fall got %0b want 1", vtpg_rst_n); end
        rd(4'hA, d, v);
        n_cmp++; if (d !== 16'd9) begin n_bad++; $display("FAIL reen_status got %0d want 9", d); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (vtpg_rst_n !== 1'b0) begin n_bad++; $display("FAIL async_vtpg_rst_n got %0b want 0", vtpg_rst_n); end
        n_cmp++; if (tH_END !== 12'd799) begin n_bad++; $display("FAIL async_tH_END got %0d want 799", tH_END); end
        n_cmp++; if (tHACT_END !== 12'd640) begin n_bad++; $display("FAIL async_tHACT_END got %0d want 640", tHACT_END); end
        n_cmp++; if (rd_data !== 16'd0 || rd_vld !== 1'b0) begin n_bad++; $display("FAIL async_rd got %0d/%0b want 0/0", rd_data, rd_vld); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_start();
        test_commit();
        test_coincident();
        test_rw_same();
        test_frame_cnt();
        test_stop();
        test_reenable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
